// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: per-port outstanding-request tracker that gates pipeline advance
module mem_stall_ctrl #(
  parameter int                   NUM_PORTS = 2,
  parameter int                   DEPTH     = 1,
  parameter int                   CNT_W     = $clog2(DEPTH + 1),
  parameter logic [NUM_PORTS-1:0] INIT_PEND = NUM_PORTS'(1),
  parameter int                   TIMEOUT   = 0,
  parameter int                   TO_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       req,
  input  logic [NUM_PORTS-1:0]       resp,
  output logic                       move,
  output logic [NUM_PORTS-1:0]       hold,
  output logic [NUM_PORTS-1:0]       issue_ok,
  output logic [NUM_PORTS*CNT_W-1:0] pending,
  output logic                       proto_err,
  output logic                       timeout
);
  localparam logic [CNT_W-1:0] DMAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [TO_W-1:0]  TLIM = TO_W'(TIMEOUT - 1);
  logic [CNT_W-1:0]     cnt_q [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] done_q, done_d, acc_req, val_resp;
  logic [TO_W-1:0]      stall_q, stall_d;
  logic                 proto_err_q, proto_err_d, timeout_q, timeout_d;
  assign hold      = done_q;
  assign proto_err = proto_err_q;
  assign timeout   = timeout_q;
  // Drain detection, issue permission and next-state for counters, done flags, watchdog and error
  always_comb begin
    move        = rst;
    pending     = '0;
    acc_req     = '0;
    val_resp    = '0;
    issue_ok    = '0;
    proto_err_d = proto_err_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      issue_ok[i] = (cnt_q[i] < DMAX) & ~done_q[i] & rst;
      acc_req[i]  = req[i] & issue_ok[i];
      val_resp[i] = resp[i] & (cnt_q[i] != '0);
      pending[i*CNT_W +: CNT_W] = cnt_q[i];
      move = move & ((cnt_q[i] == '0) | ((cnt_q[i] == ONE) & val_resp[i]));
      proto_err_d = proto_err_d | (req[i] & ~issue_ok[i]) | (resp[i] & (cnt_q[i] == '0));
    end
    done_d = done_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i] = (acc_req[i] & ~val_resp[i]) ? cnt_q[i] + ONE :
                 (val_resp[i] & ~acc_req[i]) ? cnt_q[i] - ONE : cnt_q[i];
      done_d[i] = move ? 1'b0 :
                  (val_resp[i] & ~acc_req[i] & (cnt_q[i] == ONE)) ? 1'b1 : done_q[i];
    end
    stall_d   = move ? '0 : (stall_q == '1) ? stall_q : stall_q + TO_W'(1);
    timeout_d = timeout_q | ((TIMEOUT != 0) & ~move & (stall_q == TLIM));
  end
  // State registers; reset reloads the in-flight counts and clears everything else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= CNT_W'(INIT_PEND[i]);
      done_q      <= '0;
      stall_q     <= '0;
      proto_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= cnt_d[i];
      done_q      <= done_d;
      stall_q     <= stall_d;
      proto_err_q <= proto_err_d;
      timeout_q   <= timeout_d;
    end
  end
endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb_mem_stall_ctrl: scoreboard bench driving directed and random traffic against a reference model
module tb_mem_stall_ctrl;
  localparam int N  = 3;
  localparam int D  = 2;
  localparam int CW = $clog2(D + 1);
  localparam logic [N-1:0] INIT = 3'b001;
  localparam int T  = 6;
  localparam int TW = 16;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req, resp, hold, issue_ok;
  logic [N*CW-1:0] pending;
  logic move, proto_err, timeout;

  mem_stall_ctrl #(.NUM_PORTS(N), .DEPTH(D), .INIT_PEND(INIT), .TIMEOUT(T), .TO_W(TW)) dut (
    .clk(clk), .rst(rst), .req(req), .resp(resp), .move(move), .hold(hold),
    .issue_ok(issue_ok), .pending(pending), .proto_err(proto_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          mv;
    logic [N-1:0]  hold;
    logic [N-1:0]  iok;
    logic [N*CW-1:0] pend;
    logic          pe;
    logic          to;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;

  int  m_cnt[N];
  bit  m_done[N];
  int  m_stall;
  bit  m_pe, m_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: counts per port as integers, advancing one step per cycle
  task automatic step(input logic [N-1:0] rq, input logic [N-1:0] rs, input logic rn);
    exp_t e;
    bit mv;
    if (!rn) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = int'(INIT[i]);
        m_done[i] = 0;
      end
      m_stall = 0;
      m_pe = 0;
      m_to = 0;
    end
    mv = rn;
    for (int i = 0; i < N; i++)
      if (!(m_cnt[i] == 0 || (m_cnt[i] == 1 && rs[i]))) mv = 0;
    e.mv = mv;
    e.pend = '0;
    for (int i = 0; i < N; i++) begin
      e.hold[i] = m_done[i];
      e.iok[i]  = rn && m_cnt[i] < D && !m_done[i];
      e.pend[i*CW +: CW] = CW'(m_cnt[i]);
    end
    e.pe = m_pe;
    e.to = m_to;
    q.push_back(e);
    if (rn) begin
      for (int i = 0; i < N; i++) begin
        bit a, v;
        int nc;
        a = rq[i] && e.iok[i];
        v = rs[i] && m_cnt[i] > 0;
        if (rq[i] && !e.iok[i]) m_pe = 1;
        if (rs[i] && m_cnt[i] == 0) m_pe = 1;
        nc = m_cnt[i] + int'(a) - int'(v);
        if (!mv && v && nc == 0) m_done[i] = 1;
        if (mv) m_done[i] = 0;
        m_cnt[i] = nc;
      end
      if (T != 0 && !mv && m_stall == T - 1) m_to = 1;
      m_stall = mv ? 0 : ((m_stall + 1 > (1 << TW) - 1) ? m_stall : m_stall + 1);
    end
  endtask

  task automatic drive(input logic [N-1:0] rq, input logic [N-1:0] rs, input logic rn);
    @(posedge clk);
    #1;
    req = rq;
    resp = rs;
    rst = rn;
    step(rq, rs, rn);
  endtask

  // Monitor: every cycle the DUT presents outputs; compare against the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("move", 32'(move), 32'(e.mv));
        chk("hold", 32'(hold), 32'(e.hold));
        chk("issue_ok", 32'(issue_ok), 32'(e.iok));
        chk("pending", 32'(pending), 32'(e.pend));
        chk("proto_err", 32'(proto_err), 32'(e.pe));
        chk("timeout", 32'(timeout), 32'(e.to));
      end
    end
  end

  initial begin
    logic [N-1:0] rq, rs;
    rst = 1'b0;
    req = '0;
    resp = '0;
    for (int i = 0; i < 3; i++) drive('0, '0, 1'b0);
    drive('0, '0, 1'b1);
    drive('0, '0, 1'b1);
    drive('0, 3'b001, 1'b1);
    drive(3'b011, '0, 1'b1);
    drive('0, 3'b001, 1'b1);
    drive(3'b001, '0, 1'b1);
    drive('0, '0, 1'b1);
    drive('0, 3'b010, 1'b1);
    drive(3'b001, 3'b011, 1'b1);
    drive('0, '0, 1'b1);
    drive(3'b100, 3'b001, 1'b1);
    drive(3'b100, '0, 1'b1);
    drive(3'b100, '0, 1'b1);
    drive(3'b100, 3'b100, 1'b1);
    drive('0, 3'b100, 1'b1);
    drive('0, 3'b100, 1'b1);
    drive('0, 3'b010, 1'b1);
    drive('0, '0, 1'b0);
    for (int i = 0; i < 9; i++) drive('0, '0, 1'b1);
    drive('0, 3'b001, 1'b1);
    drive('0, '0, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      rq = N'($urandom) & N'($urandom);
      rs = N'($urandom);
      drive(rq, rs, $urandom_range(0, 63) != 0);
    end
    drive('0, '0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mem_stall_ctrl.md
Name: mem_stall_ctrl

Overview:
- Parametrised pipeline stall controller for an N-port memory interface; port 0 is instruction fetch, ports 1..N-1 are data/other memory ports.
- Tracks outstanding requests per port, up to DEPTH each, and asserts `move` when every port has drained.
- Holds completed ports so they do not re-issue while others are still pending.
- Adds a stall watchdog and protocol-error flagging. Sits between the pipeline stage-enable logic and the memory request/response ports.

Parameters:
- NUM_PORTS, 2, number of memory ports (>=1); bit 0 is fetch.
- DEPTH, 1, maximum outstanding requests per port (>=1).
- CNT_W, $clog2(DEPTH+1), per-port counter width (derived).
- INIT_PEND, 1 (NUM_PORTS bits), per-port outstanding count (0/1) loaded at reset; models the fetch in flight out of reset.
- TIMEOUT, 0, stalled-cycle limit for the watchdog; 0 disables it.
- TO_W, 16, watchdog counter width; TIMEOUT < 2**TO_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low; synchronous deassert is provided upstream.
- req  in  NUM_PORTS  per-port request issued this cycle.
- resp  in  NUM_PORTS  per-port response returned this cycle.
- move  out  1  pipeline advance enable.
- hold  out  NUM_PORTS  port finished for the current step; must not issue.
- issue_ok  out  NUM_PORTS  port may issue a request this cycle.
- pending  out  NUM_PORTS*CNT_W  per-port outstanding counts, port i at [i*CNT_W +: CNT_W].
- proto_err  out  1  sticky protocol error.
- timeout  out  1  sticky watchdog expiry.

Behaviour:
- Reset (rst=0, async):
  - cnt[i] <= INIT_PEND[i]; done[i] <= 0; stall_cnt <= 0; proto_err <= 0; timeout <= 0.
  - While rst=0, move=0, issue_ok=0, hold=0 (forced combinationally).
- Accepted request: acc_req[i] = req[i] & issue_ok[i].
- Valid response: val_resp[i] = resp[i] & (cnt[i]!=0).
- Counter update, evaluated per port:
  - acc_req only: cnt+1.
  - val_resp only: cnt-1.
  - Both in the same cycle: unchanged.
  - cnt never exceeds DEPTH and never underflows.
- Port drained: drained[i] = (cnt[i]==0) | (cnt[i]==1 & val_resp[i]).
- move = AND over i of drained[i]. It is combinational, so it rises in the same cycle as the last response (zero-cycle latency).
  - Requests accepted in the move cycle belong to the next step and do not affect move.
- done[i]:
  - Set when cnt[i] reaches 0 via val_resp while move=0.
  - Cleared on any cycle with move=1; clearing has priority.
  - hold[i] = done[i].
- issue_ok[i] = (cnt[i] < DEPTH) & ~done[i] & rst.
- proto_err is set, sticky until reset, on any of:
  - req[i] while issue_ok[i]=0 (the request is ignored).
  - resp[i] while cnt[i]==0 (the response is ignored).
- Watchdog:
  - stall_cnt increments each cycle with move=0 and clears on move=1.
  - stall_cnt saturates at 2**TO_W-1.
  - If TIMEOUT!=0 and stall_cnt==TIMEOUT-1 while move=0, timeout is set (sticky until reset).
- No FSM enum. State is {cnt[], done[], stall_cnt, flags}.
  - Per-port phases: IDLE (cnt=0, done=0), WAIT (cnt>0), DONE (cnt=0, done=1).
  - Transitions: IDLE->WAIT on acc_req; WAIT->DONE on last val_resp with move=0; WAIT->IDLE on last val_resp with move=1; DONE->IDLE on move; DONE->WAIT is impossible (issue blocked).
- Simultaneous response on all ports in one cycle: move=1 that cycle, and no port enters DONE.
- Reset mid-operation: all counts are discarded; responses arriving after reset for pre-reset requests are flagged by proto_err unless absorbed by INIT_PEND.
- NUM_PORTS=1: move tracks port 0 alone; hold is never set.

Test Plan:
- Reset release, defaults (N=2, D=1, INIT_PEND=01): pending={0,1}, move=0; resp[0]=1 in cycle 3 -> move=1 in cycle 3; pending[0]=0 in cycle 4.
- Fetch returns before data: req[1] with cnt[1]=1, resp[0] in cycle 5, resp[1] in cycle 8 -> hold[0]=1 in cycles 6-8, issue_ok[0]=0 in cycles 6-8, move=1 only in cycle 8, hold[0]=0 in cycle 9.
- Same-cycle responses on both ports -> move=1 that cycle; hold stays 00; a new req[0] in that cycle is accepted and pending[0]=1 next cycle.
- DEPTH=2: two back-to-back req[1] -> pending[1]=2, issue_ok[1]=0; a third req[1] sets proto_err=1 and pending stays 2; req+resp in the same cycle leaves pending unchanged.
- Spurious resp[1] with pending[1]=0 -> proto_err=1 next cycle; counts are unchanged.
- TIMEOUT=4, no response for 4 cycles -> timeout=1 after the 4th stalled cycle; a later response gives move=1, but timeout stays 1 until rst=0.
